// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: major opcodes, ALU/branch operation
// codes and immediate-format select values used by the decoder slice.
package rv32i_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    typedef enum logic [4:0] {
        ALU_NONE  = 5'd0,
        ALU_PASSB = 5'd1,
        ALU_ADD   = 5'd2,
        ALU_SUB   = 5'd3,
        ALU_SLL   = 5'd4,
        ALU_SLT   = 5'd5,
        ALU_SLTU  = 5'd6,
        ALU_XOR   = 5'd7,
        ALU_SRL   = 5'd8,
        ALU_SRA   = 5'd9,
        ALU_OR    = 5'd10,
        ALU_AND   = 5'd11,
        ALU_BEQ   = 5'd12,
        ALU_BNE   = 5'd13,
        ALU_BLT   = 5'd14,
        ALU_BGE   = 5'd15,
        ALU_BLTU  = 5'd16,
        ALU_BGEU  = 5'd17
    } alu_op_e;

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

endpackage

// File: rtl/rv32i_decode_comb.sv
// Pure combinational RV32I decode: maps an instruction word to an
// ALU/branch operation, an immediate format, a halt request for
// SYSTEM/FENCE and an illegal-instruction flag.
module rv32i_decode_comb
    import rv32i_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [4:0]  alu_op,
    output logic [2:0]  imm_sel,
    output logic        halt_req,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    alu_op_e    op_sel;

    // Register/rd fields play no part in classification; folded here so
    // the unused bits are visibly intentional.
    logic       unused_fields;

    assign opcode        = instruction[6:0];
    assign funct3        = instruction[14:12];
    assign funct7        = instruction[31:25];
    assign unused_fields = ^{instruction[24:15], instruction[11:7]};
    assign alu_op        = op_sel;

    // Every legal opcode ends in 2'b11, so a word with other low bits
    // falls through to the default arm and is flagged illegal.
    always_comb begin
        op_sel   = ALU_NONE;
        imm_sel  = IMM_NONE;
        halt_req = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OP: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: op_sel = ALU_ADD;
                        3'b001: op_sel = ALU_SLL;
                        3'b010: op_sel = ALU_SLT;
                        3'b011: op_sel = ALU_SLTU;
                        3'b100: op_sel = ALU_XOR;
                        3'b101: op_sel = ALU_SRL;
                        3'b110: op_sel = ALU_OR;
                        3'b111: op_sel = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    op_sel = ALU_SUB;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
                    op_sel = ALU_SRA;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                imm_sel = IMM_I;
                case (funct3)
                    3'b000: op_sel = ALU_ADD;
                    3'b010: op_sel = ALU_SLT;
                    3'b011: op_sel = ALU_SLTU;
                    3'b100: op_sel = ALU_XOR;
                    3'b110: op_sel = ALU_OR;
                    3'b111: op_sel = ALU_AND;
                    3'b001: begin
                        if (funct7 == 7'b0000000) op_sel = ALU_SLL;
                        else                      illegal = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000)      op_sel = ALU_SRL;
                        else if (funct7 == 7'b0100000) op_sel = ALU_SRA;
                        else                           illegal = 1'b1;
                    end
                endcase
            end
            LOAD: begin
                if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
                    illegal = 1'b1;
                end else begin
                    op_sel  = ALU_ADD;
                    imm_sel = IMM_I;
                end
            end
            STORE: begin
                if (funct3[2] || funct3 == 3'b011) begin
                    illegal = 1'b1;
                end else begin
                    op_sel  = ALU_ADD;
                    imm_sel = IMM_S;
                end
            end
            BRANCH: begin
                imm_sel = IMM_B;
                case (funct3)
                    3'b000: op_sel = ALU_BEQ;
                    3'b001: op_sel = ALU_BNE;
                    3'b100: op_sel = ALU_BLT;
                    3'b101: op_sel = ALU_BGE;
                    3'b110: op_sel = ALU_BLTU;
                    3'b111: op_sel = ALU_BGEU;
                    default: begin
                        imm_sel = IMM_NONE;
                        illegal = 1'b1;
                    end
                endcase
            end
            JAL: begin
                op_sel  = ALU_ADD;
                imm_sel = IMM_J;
            end
            JALR: begin
                op_sel  = ALU_ADD;
                imm_sel = IMM_I;
            end
            LUI: begin
                op_sel  = ALU_PASSB;
                imm_sel = IMM_U;
            end
            AUIPC: begin
                op_sel  = ALU_ADD;
                imm_sel = IMM_U;
            end
            SYSTEM, FENCE: begin
                halt_req = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv32i_decoder.sv
// Registered RV32I decoder: one-cycle latency ALU/branch op and
// immediate-format select, plus a sticky halt for SYSTEM/FENCE.
// Build option DECODER_ILLEGAL_HALT_EN: when defined, an illegal
// instruction also sets the sticky halt.
module rv32i_decoder
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instruction,
    output logic [4:0]      ALU_op_d,
    output logic [2:0]      immsel,
    output logic            halt
);

    logic [4:0] dec_op;
    logic [2:0] dec_imm;
    logic       dec_halt_req;
    logic       dec_illegal;
    logic       set_halt;

    rv32i_decode_comb u_decode (
        .instruction (instruction),
        .alu_op      (dec_op),
        .imm_sel     (dec_imm),
        .halt_req    (dec_halt_req),
        .illegal     (dec_illegal)
    );

`ifdef DECODER_ILLEGAL_HALT_EN
    assign set_halt = dec_halt_req | dec_illegal;
`else
    // Illegal words only zero the codes in this build.
    logic unused_illegal;
    assign unused_illegal = dec_illegal;
    assign set_halt       = dec_halt_req;
`endif

    // Capture decode every cycle; halt only clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_op_d <= 5'd0;
            immsel   <= 3'd0;
            halt     <= 1'b0;
        end else begin
            ALU_op_d <= dec_op;
            immsel   <= dec_imm;
            halt     <= halt | set_halt;
        end
    end

endmodule

// File: tb/tb_rv32i_decoder.sv
// Directed self-checking bench for rv32i_decoder with hand-computed
// expected codes; honours DECODER_ILLEGAL_HALT_EN for illegal halts.
module tb_rv32i_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [4:0]  ALU_op_d;
    logic [2:0]  immsel;
    logic        halt;

    int total = 0;
    int bad   = 0;
    logic ill_halt;

    rv32i_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .ALU_op_d    (ALU_op_d),
        .immsel      (immsel),
        .halt        (halt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive a word away from the edge, then sample just after the edge.
    task automatic applyStimulus(input logic [31:0] instr);
        @(negedge clk);
        instruction = instr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] exp_op,
                               input logic [2:0] exp_imm, input logic exp_halt);
        total++;
        assert (ALU_op_d === exp_op) else begin
            bad++;
            $error("[TB] FAIL %s op observed=%0d expected=%0d", tag, ALU_op_d, exp_op);
        end
        total++;
        assert (immsel === exp_imm) else begin
            bad++;
            $error("[TB] FAIL %s immsel observed=%0d expected=%0d", tag, immsel, exp_imm);
        end
        total++;
        assert (halt === exp_halt) else begin
            bad++;
            $error("[TB] FAIL %s halt observed=%0d expected=%0d", tag, halt, exp_halt);
        end
    endtask

    initial begin
`ifdef DECODER_ILLEGAL_HALT_EN
        ill_halt = 1'b1;
`else
        ill_halt = 1'b0;
`endif
        rst_n       = 1'b0;
        instruction = 32'h00638133;
        #2;
        checkOutput("reset_async", 5'd0, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_held_edge", 5'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h00638133); checkOutput("add",      5'd2,  3'd0, 1'b0);
        applyStimulus(32'h40638133); checkOutput("sub",      5'd3,  3'd0, 1'b0);
        applyStimulus(32'h0063D133); checkOutput("srl",      5'd8,  3'd0, 1'b0);
        applyStimulus(32'h4063D133); checkOutput("sra",      5'd9,  3'd0, 1'b0);
        applyStimulus(32'h008000EF); checkOutput("jal",      5'd2,  3'd5, 1'b0);
        applyStimulus(32'h000120B7); checkOutput("lui",      5'd1,  3'd4, 1'b0);
        applyStimulus(32'h00000097); checkOutput("auipc",    5'd2,  3'd4, 1'b0);
        applyStimulus(32'h000080E7); checkOutput("jalr",     5'd2,  3'd1, 1'b0);
        applyStimulus(32'h00639463); checkOutput("bne",      5'd13, 3'd3, 1'b0);
        applyStimulus(32'h00638463); checkOutput("beq",      5'd12, 3'd3, 1'b0);
        applyStimulus(32'h0063F463); checkOutput("bgeu",     5'd17, 3'd3, 1'b0);
        applyStimulus(32'h00112023); checkOutput("sw",       5'd2,  3'd2, 1'b0);
        applyStimulus(32'h0000A083); checkOutput("lw",       5'd2,  3'd1, 1'b0);
        applyStimulus(32'h00500093); checkOutput("addi",     5'd2,  3'd1, 1'b0);
        applyStimulus(32'h40000093); checkOutput("addi_b30", 5'd2,  3'd1, 1'b0);
        applyStimulus(32'h00505093); checkOutput("srli",     5'd8,  3'd1, 1'b0);
        applyStimulus(32'h40505093); checkOutput("srai",     5'd9,  3'd1, 1'b0);

        // Illegal words: zero codes, halt only in the illegal-halt build.
        applyStimulus(32'h40639133); checkOutput("ill_f7_sll",  5'd0, 3'd0, ill_halt);
        applyStimulus(32'h02638133); checkOutput("ill_f7_mul",  5'd0, 3'd0, ill_halt);
        applyStimulus(32'h0063A463); checkOutput("ill_br_f3",   5'd0, 3'd0, ill_halt);
        applyStimulus(32'h0000B083); checkOutput("ill_ld_f3",   5'd0, 3'd0, ill_halt);
        applyStimulus(32'h00638130); checkOutput("ill_low_bits",5'd0, 3'd0, ill_halt);
        applyStimulus(32'h0000007F); checkOutput("ill_opcode",  5'd0, 3'd0, ill_halt);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_pulse1", 5'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h00000073); checkOutput("ecall",       5'd0, 3'd0, 1'b1);
        applyStimulus(32'h00500093); checkOutput("addi_halted", 5'd2, 3'd1, 1'b1);
        applyStimulus(32'h00638133); checkOutput("add_halted",  5'd2, 3'd0, 1'b1);

        // Asynchronous clear mid-cycle with non-zero outputs and halt set.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_halt", 5'd0, 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'h00638133); checkOutput("add_after_rst", 5'd2, 3'd0, 1'b0);
        applyStimulus(32'h0000000F); checkOutput("fence",         5'd0, 3'd0, 1'b1);
        applyStimulus(32'h000120B7); checkOutput("lui_halted",    5'd1, 3'd4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
